// File: rtl/instr_buff.sv
// Instruction buffer between the program loader and the fetch stage: a DEPTH-entry FIFO
// sequenced by an IDLE/FILL/DRAIN/TERM program-load FSM. Define INSTR_BUFF_FWFT_EN for a first-word fall-through read port.
module instr_buff #(
  parameter int  DEPTH   = 16,
  parameter int  CNT_W   = $clog2(DEPTH) + 1,
  parameter type instr_t = logic [31:0]
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Start,
  input  logic             I_We,
  input  logic             I_Last,
  input  instr_t           I_Wr_Instr,
  output logic             O_Full,
  input  logic             I_Re,
  output instr_t           O_Instr,
  output logic             O_Empty,
  output logic             O_Term,
  output logic [CNT_W-1:0] O_Count,
  output logic [1:0]       O_State
);

  // Handshake: a write transfers on a rising edge when I_We=1 and O_Full=0 in FILL.
  // A read transfers when I_Re=1 and O_Empty=0 in FILL or DRAIN. I_Start overrides both.
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] TERM  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  instr_t           mem [DEPTH];

  logic empty;
  logic full;
  logic wr_acc;
  logic rd_acc;

  // Occupancy, not pointer equality, separates full from empty.
  assign empty  = (count == '0) || (state == IDLE) || (state == TERM);
  assign full   = (count == CNT_W'(DEPTH));
  assign wr_acc = !I_Start && (state == FILL) && I_We && !full;
  assign rd_acc = !I_Start && ((state == FILL) || (state == DRAIN)) && I_Re && !empty;

  always_comb begin
    state_nxt = state;
    if (I_Start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        FILL:    if (wr_acc && I_Last) state_nxt = DRAIN;
        DRAIN:   if (count == '0) state_nxt = TERM;
        TERM:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (I_Start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is readable.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= I_Wr_Instr;
  end

`ifdef INSTR_BUFF_FWFT_EN
  assign O_Instr = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      O_Instr <= '0;
    end else if (rd_acc) begin
      O_Instr <= mem[rd_ptr];
    end
  end
`endif

  assign O_Empty = empty;
  assign O_Full  = full;
  assign O_Term  = (state == TERM);
  assign O_Count = count;
  assign O_State = state;

endmodule

// File: doc/instr_buff.md
INSTR_BUFF -- requirements
Module: instr_buff

Interface
REQ-001 Parameter DEPTH, default 16, entries in buffer; power of two, >= 2.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, occupancy counter width.
REQ-003 clock  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 I_Start  input  1  flush buffer and open a new program load.
REQ-006 I_We  input  1  write-enable from instruction loader.
REQ-007 I_Last  input  1  qualifies I_We; marks the written word as final instruction of program.
REQ-008 I_Wr_Instr  input  instr_t  instruction to write.
REQ-009 O_Full  output  1  buffer holds DEPTH entries.
REQ-010 I_Re  input  1  read-enable from fetch stage.
REQ-011 O_Instr  output  instr_t  instruction to fetch stage.
REQ-012 O_Empty  output  1  no readable entry.
REQ-013 O_Term  output  1  one-cycle pulse: program fully drained.
REQ-014 O_Count  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-015 FSM states: IDLE, FILL, DRAIN, TERM; O_Empty, O_Full and O_Term are derived from state and the registered occupancy only.
REQ-016 IDLE -> FILL on I_Start; FILL -> DRAIN on accepted write with I_Last=1; DRAIN -> TERM when occupancy is 0; TERM -> IDLE unconditionally after one cycle.
REQ-017 I_Start in any state: write/read pointers and count cleared to 0, state -> FILL next cycle; concurrent I_We/I_Re that cycle ignored.
REQ-018 Write accepted only when state FILL, I_We=1, O_Full=0; stores at write pointer, pointer +1 modulo DEPTH.
REQ-019 Writes in IDLE, DRAIN, TERM or while O_Full=1 are dropped; no state change.
REQ-020 Read accepted only when I_Re=1 and O_Empty=0, in FILL or DRAIN; read pointer +1 modulo DEPTH.
REQ-021 Same-cycle accepted read and write: count unchanged; both pointers advance.
REQ-022 Full and I_Re and I_We same cycle: read accepted, write dropped (O_Full registered), count -> DEPTH-1.
REQ-023 O_Empty=1 when count=0 or state IDLE/TERM; O_Full=1 when count=DEPTH.
REQ-024 Accepted write with I_Last to empty buffer: count 1, state DRAIN; TERM entered only after that entry is read.
REQ-025 O_Term=1 exactly in TERM state; never asserted without a preceding I_Last write.
REQ-026 O_Count tracks count with zero latency relative to the register (no extra pipeline).
REQ-027 Pointer wrap from DEPTH-1 to 0 seamless; full vs empty distinguished by count, never by pointer equality alone.

Reset
REQ-028 On reset: state IDLE, pointers 0, count 0, O_Empty=1, O_Full=0, O_Term=0, O_Count=0, O_Instr=0.
REQ-029 Reset mid-operation discards all contents; memory array need not be cleared.
REQ-030 Reset has priority over I_Start.

Configuration
REQ-031 Macro INSTR_BUFF_FWFT_EN defined: O_Instr = entry at read pointer combinationally (first-word fall-through); valid whenever O_Empty=0; advances after accepted read.
REQ-032 Macro undefined: O_Instr registered; loads entry at read pointer on accepted read, valid the cycle after; holds value otherwise.

Verification
REQ-033 Reset, I_Start, write 3 words 0xA1,0xA2,0xA3 (last on 0xA3), read 3 -> O_Instr sequence A1,A2,A3; O_Term pulse 1 cycle after third read; state IDLE next.
REQ-034 Write 16 words no reads -> O_Full=1, O_Count=16; 17th write dropped; read 16 -> data 0..15 in order, O_Empty=1.
REQ-035 Full buffer, I_Re=1 and I_We=1 same cycle -> O_Count=15, written word not stored.
REQ-036 Count=5, simultaneous read/write for 20 cycles -> O_Count stays 5, pointers wrap, order preserved.
REQ-037 I_Start with count=7 in FILL -> next cycle O_Count=0, O_Empty=1, no O_Term.
REQ-038 Reads while empty and writes in DRAIN -> no pointer/count change; run with and without INSTR_BUFF_FWFT_EN checking 0/1-cycle read latency.
